// File: rtl/riscv_dmem_mmio.sv
// Data-side memory subsystem for the riscv core: word RAM, 64-bit cycle
// counter with coherent hi/lo read, character TX FIFO and halt register.
// All accesses complete in fixed time; loads are combinational.
module riscv_dmem_mmio #(
  parameter int unsigned RAM_AW        = 10,
  parameter int unsigned TX_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2-1:0] PTR_ONE  = TX_DEPTH_LOG2'(1);
  localparam logic [TX_DEPTH_LOG2:0]   CNT_ONE  = (TX_DEPTH_LOG2 + 1)'(1);
  localparam logic [TX_DEPTH_LOG2:0]   CNT_FULL = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TXDATA,
    SEL_TXSTAT,
    SEL_CYCLO,
    SEL_CYCHI,
    SEL_HALT
  } sel_e;

  sel_e                      w_sel;
  logic [RAM_AW-1:0]         w_idx;
  logic [31:0]               w_stat;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_pop;
  logic                      w_push_req;
  logic                      w_push;
  logic                      w_ovf_set;
  logic                      w_ovf_clr;
  logic                      w_unused_addr;

  logic [31:0]               r_ram [0:(1 << RAM_AW) - 1];
  logic [7:0]                r_fifo [0:TX_DEPTH - 1];
  logic [TX_DEPTH_LOG2-1:0]  r_wp;
  logic [TX_DEPTH_LOG2-1:0]  r_rp;
  logic [TX_DEPTH_LOG2:0]    r_cnt;
  logic                      r_ovf;
  logic [63:0]               r_cyc;
  logic [31:0]               r_hi;
  logic                      r_halt;
  logic [31:0]               r_code;

  // Only the region nibble, RAM index and MMIO offset bits take part in decode.
  assign w_unused_addr = ^addr;
  assign w_idx         = addr[RAM_AW+1:2];

  // Address decode: region on addr[31:28], MMIO register on addr[4:2].
  always_comb begin
    w_sel = SEL_NONE;
    if (addr[31:28] == 4'h0) begin
      w_sel = SEL_RAM;
    end else if (addr[31:28] == 4'h1) begin
      case (addr[4:2])
        3'd0:    w_sel = SEL_TXDATA;
        3'd1:    w_sel = SEL_TXSTAT;
        3'd2:    w_sel = SEL_CYCLO;
        3'd3:    w_sel = SEL_CYCHI;
        3'd4:    w_sel = SEL_HALT;
        default: w_sel = SEL_NONE;
      endcase
    end
  end

  assign w_full     = (r_cnt == CNT_FULL);
  assign w_empty    = (r_cnt == '0);
  assign w_pop      = tx_valid && tx_ready;
  assign w_push_req = wr && (w_sel == SEL_TXDATA);
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = wr && (w_sel == SEL_TXSTAT);

  assign tx_valid  = !w_empty;
  assign tx_data   = w_empty ? '0 : r_fifo[r_rp];
  assign halt      = r_halt;
  assign halt_code = r_code;

  // TX status word: full, empty, overflow and occupancy.
  always_comb begin
    w_stat                       = '0;
    w_stat[0]                    = w_full;
    w_stat[1]                    = w_empty;
    w_stat[2]                    = r_ovf;
    w_stat[8 +: TX_DEPTH_LOG2+1] = r_cnt;
  end

  // Combinational load path; the core samples it at the next edge.
  always_comb begin
    rdata = '0;
    if (re && !reset) begin
      case (w_sel)
        SEL_RAM:    rdata = r_ram[w_idx];
        SEL_TXSTAT: rdata = w_stat;
        SEL_CYCLO:  rdata = r_cyc[31:0];
        SEL_CYCHI:  rdata = r_hi;
        SEL_HALT:   rdata = {31'b0, r_halt};
        default:    rdata = '0;
      endcase
    end
  end

  // RAM store; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && wr && (w_sel == SEL_RAM)) begin
      r_ram[w_idx] <= wdata;
    end
  end

  // TX FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= wdata[7:0];
        r_wp         <= r_wp + PTR_ONE;
      end
      if (w_pop) begin
        r_rp <= r_rp + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Free-running cycle counter; a CYCLO read snapshots the upper half.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc <= '0;
      r_hi  <= '0;
    end else begin
      r_cyc <= r_cyc + 64'd1;
      if (re && (w_sel == SEL_CYCLO)) begin
        r_hi <= r_cyc[63:32];
      end
    end
  end

  // Sticky halt flag with last-written halt code.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halt <= 1'b0;
      r_code <= '0;
    end else if (wr && (w_sel == SEL_HALT)) begin
      r_halt <= 1'b1;
      r_code <= wdata;
    end
  end

endmodule

// File: tb/tb_riscv_dmem_mmio.sv
// Self-checking bench for riscv_dmem_mmio against a queue/array reference model.
module tb_riscv_dmem_mmio;

  localparam int unsigned RAM_AW = 10;
  localparam int unsigned DEPTH  = 4;

  localparam logic [31:0] A_TXDATA = 32'h1000_0000;
  localparam logic [31:0] A_TXSTAT = 32'h1000_0004;
  localparam logic [31:0] A_CYCLO  = 32'h1000_0008;
  localparam logic [31:0] A_CYCHI  = 32'h1000_000C;
  localparam logic [31:0] A_HALT   = 32'h1000_0010;

  logic        clk;
  logic        reset;
  logic        wr;
  logic        re;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        halt;
  logic [31:0] halt_code;

  int n_checks;
  int n_fail;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [7:0]  q [$];
  logic        m_ovf;
  logic        m_halt;
  logic [31:0] m_code;
  logic [31:0] m_hi;
  logic [63:0] m_cyc;

  // Observed and expected values of the most recent cycle
  logic [31:0] s_rdata, e_rdata, s_code, e_code;
  logic        s_txv, e_txv, s_halt, e_halt;
  logic [7:0]  s_txd, e_txd;

  riscv_dmem_mmio #(.RAM_AW(RAM_AW), .TX_DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .wr(wr), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .halt(halt), .halt_code(halt_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ram_index(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << RAM_AW));
  endfunction

  function automatic logic [31:0] m_stat();
    logic [31:0] v;
    v       = '0;
    v[0]    = (q.size() == DEPTH);
    v[1]    = (q.size() == 0);
    v[2]    = m_ovf;
    v[10:8] = 3'(q.size());
    return v;
  endfunction

  function automatic logic [31:0] m_rdata(input logic r, input logic [31:0] a);
    if (!r || reset) return '0;
    if (a[31:28] == 4'h0) return ram_m.exists(ram_index(a)) ? ram_m[ram_index(a)] : 32'h0;
    if (a[31:28] != 4'h1) return '0;
    case (a[4:2])
      3'd1:    return m_stat();
      3'd2:    return m_cyc[31:0];
      3'd3:    return m_hi;
      3'd4:    return {31'b0, m_halt};
      default: return '0;
    endcase
  endfunction

  function automatic void m_edge(input logic w, input logic r, input logic [31:0] a,
                                 input logic [31:0] d, input logic rdy);
    logic pop, full, mm;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0; m_halt = 1'b0; m_code = '0; m_cyc = '0; m_hi = '0;
      return;
    end
    mm   = (a[31:28] == 4'h1);
    pop  = (q.size() != 0) && rdy;
    full = (q.size() == DEPTH);
    if (r && mm && a[4:2] == 3'd2) m_hi = m_cyc[63:32];
    if (pop) void'(q.pop_front());
    if (w && a[31:28] == 4'h0) ram_m[ram_index(a)] = d;
    if (w && mm) begin
      case (a[4:2])
        3'd0: if (!full || pop) q.push_back(d[7:0]); else m_ovf = 1'b1;
        3'd1: m_ovf = 1'b0;
        3'd4: begin m_halt = 1'b1; m_code = d; end
        default: ;
      endcase
    end
    m_cyc = m_cyc + 64'd1;
  endfunction

  // One bus cycle: called at a negedge, returns at the next negedge.
  task automatic cycle(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    wr = w; re = r; addr = a; wdata = d; tx_ready = rdy;
    #1;
    s_rdata = rdata; s_txv = tx_valid; s_txd = tx_data; s_halt = halt; s_code = halt_code;
    e_rdata = m_rdata(r, a);
    e_txv   = (q.size() != 0);
    e_txd   = (q.size() != 0) ? q[0] : 8'h00;
    e_halt  = m_halt;
    e_code  = m_code;
    m_edge(w, r, a, d, rdy);
    @(negedge clk);
    wr = 1'b0; re = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(0, 0, 32'h0, 32'h0, 0);
    cycle(0, 0, 32'h0, 32'h0, 0);
    reset = 1'b0;
    cycle(0, 1, A_CYCLO, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_cyclo: got %h want 0", s_rdata); end
    n_checks++; if (s_txv !== 1'b0) begin n_fail++; $display("FAIL reset_txv: got %b want 0", s_txv); end
    n_checks++; if (s_txd !== 8'h00) begin n_fail++; $display("FAIL reset_txd: got %h want 0", s_txd); end
    n_checks++; if (s_halt !== 1'b0 || s_code !== 32'h0) begin
      n_fail++; $display("FAIL reset_halt: got %b/%h want 0/0", s_halt, s_code); end
    cycle(0, 1, A_TXSTAT, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h2) begin n_fail++; $display("FAIL reset_txstat: got %h want 00000002", s_rdata); end
  endtask

  task automatic test_ram();
    logic [31:0] a_list [16];
    logic [31:0] a, d;
    cycle(1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    cycle(1, 0, 32'h0000_0014, 32'h1234_5678, 0);
    cycle(0, 1, 32'h0000_0010, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rd10: got %h want deadbeef", s_rdata); end
    cycle(0, 1, 32'h0000_0014, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_rd14: got %h want 12345678", s_rdata); end
    cycle(0, 1, 32'h2000_0000, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h want 0", s_rdata); end
    cycle(0, 0, 32'h0000_0010, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL re0_rd: got %h want 0", s_rdata); end
    cycle(0, 1, 32'h0ABC_D013, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_alias: got %h want deadbeef", s_rdata); end
    cycle(1, 0, 32'h2000_0010, 32'h5555_AAAA, 0);
    cycle(0, 1, 32'h0000_0010, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL unmapped_wr: got %h want deadbeef", s_rdata); end
    cycle(1, 1, 32'h0000_0014, 32'hCAFE_F00D, 0);
    n_checks++; if (s_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_re_old: got %h want 12345678", s_rdata); end
    cycle(0, 1, 32'h0000_0014, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wr_re_new: got %h want cafef00d", s_rdata); end
    for (int i = 0; i < 16; i++) begin
      a = {4'h0, 28'($urandom)};
      d = $urandom;
      a_list[i] = a;
      cycle(1, 0, a, d, 0);
    end
    for (int i = 0; i < 16; i++) begin
      a = a_list[i] ^ {$urandom_range(0, 15) << 28 & 32'h0, 16'($urandom) << 12 & 16'h0, 2'($urandom)};
      cycle(0, 1, a, 32'h0, 0);
      n_checks++; if (s_rdata !== e_rdata) begin
        n_fail++; $display("FAIL ram_rand[%0d]: addr %h got %h want %h", i, a, s_rdata, e_rdata); end
    end
  endtask

  task automatic test_cycle_counter();
    cycle(0, 1, A_CYCLO, 32'h0, 0);
    repeat (5) cycle(0, 0, 32'h0, 32'h0, 0);
    cycle(0, 1, A_CYCLO, 32'h0, 0);
    n_checks++; if (s_rdata !== e_rdata) begin n_fail++; $display("FAIL cyclo_live: got %h want %h", s_rdata, e_rdata); end
    dut.r_cyc = 64'h0000_0001_FFFF_FFFE;
    m_cyc     = 64'h0000_0001_FFFF_FFFE;
    cycle(0, 1, A_CYCLO, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cyclo_pair: got %h want fffffffe", s_rdata); end
    cycle(0, 0, 32'h0, 32'h0, 0);
    cycle(0, 1, A_CYCHI, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h1) begin n_fail++; $display("FAIL cychi_pair: got %h want 00000001", s_rdata); end
    dut.r_cyc = 64'h0000_0001_FFFF_FFFF;
    m_cyc     = 64'h0000_0001_FFFF_FFFF;
    cycle(0, 1, A_CYCLO, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cyclo_carry: got %h want ffffffff", s_rdata); end
    cycle(0, 1, A_CYCHI, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h1) begin n_fail++; $display("FAIL cychi_shadow: got %h want 00000001", s_rdata); end
    dut.r_cyc = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cyc     = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle(0, 0, 32'h0, 32'h0, 0);
    cycle(0, 1, A_CYCLO, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL cyc_wrap_lo: got %h want 0", s_rdata); end
    cycle(0, 1, A_CYCHI, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL cyc_wrap_hi: got %h want 0", s_rdata); end
    cycle(1, 0, A_CYCLO, 32'hFFFF_0000, 0);
    cycle(0, 1, A_CYCLO, 32'h0, 0);
    n_checks++; if (s_rdata !== e_rdata) begin n_fail++; $display("FAIL cyc_wr_ignored: got %h want %h", s_rdata, e_rdata); end
  endtask

  task automatic test_fifo_fill();
    for (int i = 0; i < 4; i++) cycle(1, 0, A_TXDATA, 32'h41 + i, 0);
    cycle(0, 1, A_TXSTAT, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h0000_0401) begin n_fail++; $display("FAIL fill_stat: got %h want 00000401", s_rdata); end
    cycle(1, 0, A_TXDATA, 32'h45, 0);
    cycle(0, 1, A_TXSTAT, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h0000_0405) begin n_fail++; $display("FAIL ovf_stat: got %h want 00000405", s_rdata); end
    n_checks++; if (s_txd !== 8'h41) begin n_fail++; $display("FAIL ovf_head: got %h want 41", s_txd); end
    cycle(0, 1, A_TXDATA, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL txdata_rd: got %h want 0", s_rdata); end
    cycle(1, 0, A_TXSTAT, $urandom, 0);
    cycle(0, 1, A_TXSTAT, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h0000_0401) begin n_fail++; $display("FAIL ovf_clear: got %h want 00000401", s_rdata); end
  endtask

  task automatic test_drain();
    logic [7:0] exp_b [4];
    exp_b = '{8'h41, 8'h42, 8'h43, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 32'h0, 32'h0, 1);
      n_checks++; if (s_txv !== 1'b1 || s_txd !== exp_b[i]) begin
        n_fail++; $display("FAIL drain[%0d]: got %b/%h want 1/%h", i, s_txv, s_txd, exp_b[i]); end
    end
    cycle(0, 1, A_TXSTAT, 32'h0, 1);
    n_checks++; if (s_txv !== 1'b0 || s_rdata !== 32'h2) begin
      n_fail++; $display("FAIL drain_empty: got %b/%h want 0/00000002", s_txv, s_rdata); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b [4];
    exp_b = '{8'h42, 8'h43, 8'h44, 8'h58};
    for (int i = 0; i < 4; i++) cycle(1, 0, A_TXDATA, 32'h41 + i, 0);
    cycle(1, 0, A_TXDATA, 32'h58, 1);
    n_checks++; if (s_txd !== 8'h41) begin n_fail++; $display("FAIL pp_head: got %h want 41", s_txd); end
    cycle(0, 1, A_TXSTAT, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h0000_0401) begin n_fail++; $display("FAIL pp_stat: got %h want 00000401", s_rdata); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 32'h0, 32'h0, 1);
      n_checks++; if (s_txv !== 1'b1 || s_txd !== exp_b[i]) begin
        n_fail++; $display("FAIL pp_drain[%0d]: got %b/%h want 1/%h", i, s_txv, s_txd, exp_b[i]); end
    end
  endtask

  task automatic test_random_traffic();
    logic [31:0] a;
    logic        w, r;
    for (int i = 0; i < 200; i++) begin
      w = 1'b0; r = 1'b0; a = 32'h0;
      case ($urandom_range(0, 5))
        0: begin w = 1'b1; a = A_TXDATA; end
        1: begin w = ($urandom_range(0, 3) == 0); a = A_TXSTAT; end
        2: begin r = 1'b1; a = A_TXSTAT; end
        3: begin r = 1'b1; a = A_CYCLO; end
        4: begin r = 1'b1; a = A_CYCHI; end
        default: ;
      endcase
      cycle(w, r, a, $urandom, 1'($urandom_range(0, 1)));
      n_checks++; if (s_rdata !== e_rdata || s_txv !== e_txv || s_txd !== e_txd) begin
        n_fail++;
        $display("FAIL rand[%0d]: got rd=%h v=%b d=%h want rd=%h v=%b d=%h",
                 i, s_rdata, s_txv, s_txd, e_rdata, e_txv, e_txd);
      end
    end
  endtask

  task automatic test_halt_and_reset();
    cycle(1, 0, A_HALT, 32'h0000_002A, 0);
    cycle(0, 1, A_HALT, 32'h0, 0);
    n_checks++; if (s_halt !== 1'b1 || s_code !== 32'h2A) begin
      n_fail++; $display("FAIL halt_set: got %b/%h want 1/0000002a", s_halt, s_code); end
    n_checks++; if (s_rdata !== 32'h1) begin n_fail++; $display("FAIL halt_rd: got %h want 00000001", s_rdata); end
    cycle(1, 0, A_HALT, 32'h0000_0055, 0);
    cycle(0, 0, 32'h0, 32'h0, 0);
    n_checks++; if (s_halt !== 1'b1 || s_code !== 32'h55) begin
      n_fail++; $display("FAIL halt_update: got %b/%h want 1/00000055", s_halt, s_code); end
    for (int i = 0; i < 3; i++) cycle(1, 0, A_TXDATA, 32'h61 + i, 0);
    cycle(0, 0, 32'h0, 32'h0, 1);
    reset = 1'b1;
    cycle(0, 0, 32'h0, 32'h0, 1);
    reset = 1'b0;
    cycle(0, 1, A_CYCLO, 32'h0, 0);
    n_checks++; if (s_halt !== 1'b0 || s_code !== 32'h0) begin
      n_fail++; $display("FAIL rst_halt: got %b/%h want 0/0", s_halt, s_code); end
    n_checks++; if (s_txv !== 1'b0 || s_txd !== 8'h0) begin
      n_fail++; $display("FAIL rst_fifo: got %b/%h want 0/00", s_txv, s_txd); end
    n_checks++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_cyc: got %h want 0", s_rdata); end
    cycle(0, 1, A_TXSTAT, 32'h0, 0);
    n_checks++; if (s_rdata !== 32'h2) begin n_fail++; $display("FAIL rst_stat: got %h want 00000002", s_rdata); end
    cycle(0, 1, 32'h0000_0014, 32'h0, 0);
    n_checks++; if (s_rdata !== e_rdata) begin n_fail++; $display("FAIL rst_ram: got %h want %h", s_rdata, e_rdata); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; wr = 1'b0; re = 1'b0; addr = '0; wdata = '0; tx_ready = 1'b0;
    m_ovf = 1'b0; m_halt = 1'b0; m_code = '0; m_hi = '0; m_cyc = '0;
    @(negedge clk);
    test_reset();
    test_ram();
    test_cycle_counter();
    test_fifo_fill();
    test_drain();
    test_full_push_pop();
    test_random_traffic();
    test_halt_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
